// File: rtl/id_ex_skid_reg_if.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_skid_reg_if
// Purpose  : Decode-side and EX-side valid/ready bundle for the ID->EX stage.
// Revision : 1.0
// ============================================================================
interface id_ex_skid_reg_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 5,
  parameter int REG_ADDR_W    = 5
);
  logic                     in_valid;
  logic                     in_ready;
  logic [DATA_WIDTH-1:0]    in_rs1;
  logic [DATA_WIDTH-1:0]    in_rs2;
  logic [OPCODE_LENGTH-1:0] in_opcode;
  logic [REG_ADDR_W-1:0]    in_rd_addr;
  logic [DATA_WIDTH-1:0]    in_pc;

  logic                     out_valid;
  logic                     out_ready;
  logic [DATA_WIDTH-1:0]    out_rs1;
  logic [DATA_WIDTH-1:0]    out_rs2;
  logic [OPCODE_LENGTH-1:0] out_opcode;
  logic [REG_ADDR_W-1:0]    out_rd_addr;
  logic [DATA_WIDTH-1:0]    out_pc;

  // Environment view: drives decode side and the EX ready.
  modport master (
    output in_valid, in_rs1, in_rs2, in_opcode, in_rd_addr, in_pc,
    input  in_ready,
    input  out_valid, out_rs1, out_rs2, out_opcode, out_rd_addr, out_pc,
    output out_ready
  );

  // Stage view.
  modport slave (
    input  in_valid, in_rs1, in_rs2, in_opcode, in_rd_addr, in_pc,
    output in_ready,
    output out_valid, out_rs1, out_rs2, out_opcode, out_rd_addr, out_pc,
    input  out_ready
  );
endinterface
`default_nettype wire

// File: rtl/id_ex_skid_reg.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_skid_reg
// Purpose  : ID->EX pipeline register with 2-entry skid buffer and flush.
//            Optional bubble counter enabled by `define ID_EX_BUBBLE_CNT_EN.
// Revision : 1.0
// ============================================================================
module id_ex_skid_reg #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 5,
  parameter int REG_ADDR_W    = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  id_ex_skid_reg_if.slave bus
`ifdef ID_EX_BUBBLE_CNT_EN
  ,
  output logic [15:0]     bubble_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_e;

  typedef struct packed {
    logic [DATA_WIDTH-1:0]    rs1;
    logic [DATA_WIDTH-1:0]    rs2;
    logic [OPCODE_LENGTH-1:0] opcode;
    logic [REG_ADDR_W-1:0]    rd_addr;
    logic [DATA_WIDTH-1:0]    pc;
  } payload_t;

  state_e   state_q, state_d;
  payload_t main_q, main_d;
  payload_t skid_q, skid_d;

  payload_t w_in_payload;
  logic     w_out_valid;
  logic     w_in_ready;
  logic     w_in_fire;
  logic     w_out_fire;

  assign w_in_payload = '{rs1:     bus.in_rs1,
                          rs2:     bus.in_rs2,
                          opcode:  bus.in_opcode,
                          rd_addr: bus.in_rd_addr,
                          pc:      bus.in_pc};

  // Both handshake flags decode straight from the state register.
  assign w_out_valid = (state_q != ST_EMPTY);
  assign w_in_ready  = (state_q != ST_SKID);
  assign w_in_fire   = bus.in_valid & w_in_ready;
  assign w_out_fire  = w_out_valid & bus.out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (w_in_fire) begin
            main_d  = w_in_payload;
            state_d = ST_FULL;
          end
        end
        ST_FULL: begin
          if (w_in_fire && w_out_fire) begin
            main_d = w_in_payload;
          end else if (w_in_fire) begin
            skid_d  = w_in_payload;
            state_d = ST_SKID;
          end else if (w_out_fire) begin
            // Zeroed main makes an empty stage look like a NOP to the ALU.
            main_d  = '0;
            state_d = ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (w_out_fire) begin
            main_d  = skid_q;
            skid_d  = '0;
            state_d = ST_FULL;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          main_d  = '0;
          skid_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = w_out_valid;
  assign bus.out_rs1     = main_q.rs1;
  assign bus.out_rs2     = main_q.rs2;
  assign bus.out_opcode  = main_q.opcode;
  assign bus.out_rd_addr = main_q.rd_addr;
  assign bus.out_pc      = main_q.pc;

`ifdef ID_EX_BUBBLE_CNT_EN
  logic [15:0] bubble_q, bubble_d;

  // Counts cycles where EX was ready but had nothing to execute; saturating.
  always_comb begin
    bubble_d = bubble_q;
    if (bus.out_ready && !w_out_valid && !flush && (bubble_q != 16'hFFFF)) begin
      bubble_d = bubble_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_q <= 16'd0;
    end else begin
      bubble_q <= bubble_d;
    end
  end

  assign bubble_cnt = bubble_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_id_ex_skid_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_ex_skid_reg
// Purpose  : Self-checking bench: vector table, corner sequences, random vs queue model.
// Revision : 1.0
// ============================================================================
module tb_id_ex_skid_reg;
  localparam int DW = 32;
  localparam int OL = 5;
  localparam int RW = 5;

  typedef struct packed {
    logic [DW-1:0] rs1;
    logic [DW-1:0] rs2;
    logic [OL-1:0] op;
    logic [RW-1:0] rd;
    logic [DW-1:0] pc;
  } pl_t;

  typedef struct {
    logic iv;
    int   in_id;
    logic ordy;
    logic fl;
    logic ev;
    logic er;
    int   exp_id;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  pl_t  q[$];
  vec_t tbl[14];

  always #5 clk = ~clk;

  id_ex_skid_reg_if #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OL), .REG_ADDR_W(RW)) bus();

`ifdef ID_EX_BUBBLE_CNT_EN
  logic [15:0] bubble_cnt;
`endif

  id_ex_skid_reg #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OL), .REG_ADDR_W(RW)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
`ifdef ID_EX_BUBBLE_CNT_EN
    ,
    .bubble_cnt (bubble_cnt)
`endif
  );

  function automatic pl_t mk(input int id);
    pl_t p;
    logic [31:0] u;
    u = 32'(id);
    if (id == 0) begin
      p = '0;
    end else begin
      p.rs1 = 32'hA000_0000 + u;
      p.rs2 = 32'h0B00_0000 + (u << 4);
      p.op  = u[4:0];
      p.rd  = u[4:0] + 5'd3;
      p.pc  = 32'h0000_1000 + (u << 2);
    end
    return p;
  endfunction

  function automatic pl_t cur_out();
    return {bus.out_rs1, bus.out_rs2, bus.out_opcode, bus.out_rd_addr, bus.out_pc};
  endfunction

  task automatic drive(input logic v, input pl_t p, input logic ordy, input logic fl);
    bus.in_valid   = v;
    bus.in_rs1     = p.rs1;
    bus.in_rs2     = p.rs2;
    bus.in_opcode  = p.op;
    bus.in_rd_addr = p.rd;
    bus.in_pc      = p.pc;
    bus.out_ready  = ordy;
    flush          = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic ev, input logic er, input pl_t ep);
    pl_t got;
    got = cur_out();
    vectors++;
    if (bus.out_valid !== ev || bus.in_ready !== er || got !== ep) begin
      miscompares++;
      $display("FAIL %s: got valid=%0b in_ready=%0b out=%h, want valid=%0b in_ready=%0b out=%h",
               name, bus.out_valid, bus.in_ready, got, ev, er, ep);
    end
  endtask

`ifdef ID_EX_BUBBLE_CNT_EN
  task automatic check_cnt(input string name, input logic [15:0] exp);
    vectors++;
    if (bubble_cnt !== exp) begin
      miscompares++;
      $display("FAIL %s: got bubble_cnt=%h, want %h", name, bubble_cnt, exp);
    end
  endtask
`endif

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    pl_t p;
    logic iv, ordy, fl, ev, er;

    //            iv  id ordy fl  ev  er exp
    tbl[0]  = '{1'b1, 1, 1'b0, 1'b0, 1'b1, 1'b1, 1};
    tbl[1]  = '{1'b1, 2, 1'b0, 1'b0, 1'b1, 1'b0, 1};
    tbl[2]  = '{1'b1, 3, 1'b0, 1'b0, 1'b1, 1'b0, 1};
    tbl[3]  = '{1'b0, 0, 1'b1, 1'b0, 1'b1, 1'b1, 2};
    tbl[4]  = '{1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 0};
    tbl[5]  = '{1'b1, 4, 1'b0, 1'b0, 1'b1, 1'b1, 4};
    tbl[6]  = '{1'b1, 5, 1'b0, 1'b0, 1'b1, 1'b0, 4};
    tbl[7]  = '{1'b1, 3, 1'b0, 1'b1, 1'b0, 1'b1, 0};
    tbl[8]  = '{1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 0};
    tbl[9]  = '{1'b1, 6, 1'b1, 1'b0, 1'b1, 1'b1, 6};
    tbl[10] = '{1'b1, 7, 1'b1, 1'b0, 1'b1, 1'b1, 7};
    tbl[11] = '{1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 0};
    tbl[12] = '{1'b1, 8, 1'b0, 1'b1, 1'b0, 1'b1, 0};
    tbl[13] = '{1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 0};

    drive(1'b0, mk(0), 1'b0, 1'b0);
    #12;
    check("reset_state", 1'b0, 1'b1, mk(0));
    @(negedge clk);
    rst = 1'b0;

    // Vector table: backpressure into SKID, drain, flush in SKID, flush on input.
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].iv, mk(tbl[i].in_id), tbl[i].ordy, tbl[i].fl);
      step();
      check($sformatf("table_%0d", i), tbl[i].ev, tbl[i].er, mk(tbl[i].exp_id));
    end

    // Back-to-back ADD stream at full throughput.
    for (int i = 0; i < 8; i++) begin
      p.rs1 = 32'(i);
      p.rs2 = 32'(2 * i);
      p.op  = 5'b00001;
      p.rd  = 5'(i + 1);
      p.pc  = 32'(4 * i);
      drive(1'b1, p, 1'b1, 1'b0);
      step();
      check($sformatf("stream_%0d", i), 1'b1, 1'b1, p);
    end
    drive(1'b0, mk(0), 1'b1, 1'b0);
    step();
    check("stream_drain", 1'b0, 1'b1, mk(0));

    // Async reset mid-cycle while in SKID.
    drive(1'b1, mk(9), 1'b0, 1'b0);
    step();
    drive(1'b1, mk(10), 1'b0, 1'b0);
    step();
    check("pre_rst_skid", 1'b1, 1'b0, mk(9));
    drive(1'b1, mk(11), 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst", 1'b0, 1'b1, mk(0));
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, mk(12), 1'b1, 1'b0);
    step();
    check("post_rst", 1'b1, 1'b1, mk(12));
    drive(1'b0, mk(0), 1'b1, 1'b0);
    step();
    check("post_rst_drain", 1'b0, 1'b1, mk(0));

    // Random traffic against a capacity-2 FIFO model.
    drive(1'b0, mk(0), 1'b1, 1'b1);
    step();
    q.delete();
    for (int n = 0; n < 10000; n++) begin
      ev = (q.size() > 0);
      er = (q.size() < 2);
      check("random", ev, er, ev ? q[0] : mk(0));
      iv   = (($urandom % 4) != 0);
      ordy = (($urandom % 3) != 0);
      fl   = (($urandom % 64) == 0);
      p.rs1 = $urandom;
      p.rs2 = $urandom;
      p.op  = 5'($urandom);
      p.rd  = 5'($urandom);
      p.pc  = $urandom;
      drive(iv, p, ordy, fl);
      if (fl) begin
        q.delete();
      end else begin
        if (ev && ordy) void'(q.pop_front());
        if (iv && er) q.push_back(p);
      end
      step();
    end

`ifdef ID_EX_BUBBLE_CNT_EN
    @(negedge clk);
    drive(1'b0, mk(0), 1'b1, 1'b0);
    rst = 1'b1;
    #1;
    check_cnt("bubble_reset", 16'd0);
    #1;
    rst = 1'b0;
    repeat (3) step();
    check_cnt("bubble_3", 16'd3);
    repeat (65535) step();
    check_cnt("bubble_sat", 16'hFFFF);
    step();
    check_cnt("bubble_sat_hold", 16'hFFFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
